// File: rtl/pulse_period_meter_if.sv
// Measurement bus of the pulse period meter: the sampled pin plus the
// published period/high/low counts with their strobe and loss flag.
interface pulse_period_meter_if #(
  parameter int COUNT_WIDTH = 26
);
  logic                   Signal_in;
  logic [COUNT_WIDTH-1:0] Period_count;
  logic [COUNT_WIDTH-1:0] High_count;
  logic [COUNT_WIDTH-1:0] Low_count;
  logic                   Measure_valid;
  logic                   Signal_lost;

  // Meter side: samples the pin, drives the results
  modport master (
    input  Signal_in,
    output Period_count, High_count, Low_count, Measure_valid, Signal_lost
  );

  // Pin driver / status consumer side
  modport slave (
    output Signal_in,
    input  Period_count, High_count, Low_count, Measure_valid, Signal_lost
  );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures period, high time and low time of an asynchronous square wave
// in Clock cycles; strobes each completed period and flags loss of signal
// when no rising edge arrives within the timeout.
module pulse_period_meter #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int TIMEOUT_MS      = 1000,
  parameter int COUNT_WIDTH     = 26
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  pulse_period_meter_if.master mon
);

  localparam longint TIMEOUT_L = (longint'(CLOCK_FREQUENCY) * longint'(TIMEOUT_MS)) / 1000;
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_CYCLES = COUNT_WIDTH'(TIMEOUT_L);

  // Timeout must leave headroom so the counter can never wrap
  generate
    if (TIMEOUT_L < 2 || TIMEOUT_L >= (longint'(1) << COUNT_WIDTH) - 1) begin : g_bad_timeout
      $error("pulse_period_meter: TIMEOUT_CYCLES out of range");
    end
    if ($bits(mon.Period_count) != COUNT_WIDTH) begin : g_bad_width
      $error("pulse_period_meter: interface COUNT_WIDTH mismatch");
    end
  endgenerate

  typedef enum logic {WAIT_FIRST, MEASURE} state_t;

  state_t                 state, state_nxt;
  logic                   s1, s2, s3;
  logic                   rise, fall, timeout;
  logic [COUNT_WIDTH-1:0] cnt, high_lat;
  logic [COUNT_WIDTH-1:0] period_q, high_q, low_q;
  logic                   valid_q, lost_q;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon.Signal_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= WAIT_FIRST;
    else          state <= state_nxt;
  end

  // Next state: first rise arms, timeout without a rise drops back
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      WAIT_FIRST: if (rise) state_nxt = MEASURE;
      MEASURE: begin
        if (!rise && cnt == TIMEOUT_CYCLES) begin
          timeout   = 1'b1;
          state_nxt = WAIT_FIRST;
        end
      end
      default: state_nxt = WAIT_FIRST;
    endcase
  end

  // Counter, high-time latch and registered results; a rise beats a timeout
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt      <= '0;
      high_lat <= '0;
      period_q <= '0;
      high_q   <= '0;
      low_q    <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          cnt      <= rise ? COUNT_WIDTH'(1) : '0;
          high_lat <= '0;
        end
        MEASURE: begin
          if (rise) begin
            period_q <= cnt;
            high_q   <= high_lat;
            low_q    <= cnt - high_lat;
            valid_q  <= 1'b1;
            lost_q   <= 1'b0;
            cnt      <= COUNT_WIDTH'(1);
          end else if (timeout) begin
            period_q <= '0;
            high_q   <= '0;
            low_q    <= '0;
            lost_q   <= 1'b1;
            cnt      <= '0;
            high_lat <= '0;
          end else begin
            cnt <= cnt + COUNT_WIDTH'(1);
            if (fall) high_lat <= cnt;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign mon.Period_count  = period_q;
  assign mon.High_count    = high_q;
  assign mon.Low_count     = low_q;
  assign mon.Measure_valid = valid_q;
  assign mon.Signal_lost   = lost_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter with TIMEOUT_CYCLES = 100.
module tb_pulse_period_meter;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;

  pulse_period_meter_if #(.COUNT_WIDTH(26)) bus ();

  pulse_period_meter #(
    .CLOCK_FREQUENCY(1000),
    .TIMEOUT_MS     (100),
    .COUNT_WIDTH    (26)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .mon    (bus)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int nstb   = 0;
  int stb_cyc = 0, prev_stb_cyc = 0;
  int first_lost = -1;
  longint last_p = 0, last_h = 0, last_l = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // Strobe monitor: captures each published measurement
  always @(posedge Clock) begin
    #1;
    if (bus.Measure_valid === 1'b1) begin
      nstb++;
      prev_stb_cyc = stb_cyc;
      stb_cyc      = cyc;
      last_p       = bus.Period_count;
      last_h       = bus.High_count;
      last_l       = bus.Low_count;
      if (nstb == 1) first_lost = int'(bus.Signal_lost);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // n periods of h cycles high then l cycles low, changing on negedges
  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      bus.Signal_in = 1'b1;
      repeat (h) @(negedge Clock);
      bus.Signal_in = 1'b0;
      repeat (l) @(negedge Clock);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_lost"},   bus.Signal_lost,   1);
    chk({tag, "_valid"},  bus.Measure_valid, 0);
    chk({tag, "_period"}, bus.Period_count,  0);
    chk({tag, "_high"},   bus.High_count,    0);
    chk({tag, "_low"},    bus.Low_count,     0);
  endtask

  initial begin
    int n0, lost_cyc, ref_cyc;
    bit seen;
    bus.Signal_in = 1'b0;
    repeat (3) @(negedge Clock);
    chk_cleared("rst0");
    Reset_n = 1'b1;
    @(negedge Clock);

    // 10 high / 10 low: six rises, first only arms
    wave(10, 10, 6);
    chk("t2_nstb",    nstb, 5);
    chk("t2_period",  last_p, 20);
    chk("t2_high",    last_h, 10);
    chk("t2_low",     last_l, 10);
    chk("t2_spacing", stb_cyc - prev_stb_cyc, 20);
    chk("t2_lost1st", first_lost, 0);
    chk("t2_lost",    bus.Signal_lost, 0);

    // Duty change, then fastest square wave
    wave(3, 17, 2);
    chk("t3_period", last_p, 20);
    chk("t3_high",   last_h, 3);
    chk("t3_low",    last_l, 17);
    wave(1, 1, 8);
    chk("t3_p2",     last_p, 2);
    chk("t3_h2",     last_h, 1);
    chk("t3_l2",     last_l, 1);

    // Hold low: loss 100 edges after the last strobe
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge Clock); #1;
      if (bus.Signal_lost) begin seen = 1'b1; break; end
    end
    lost_cyc = cyc;
    ref_cyc  = stb_cyc;
    chk("t4_lost_seen", seen, 1);
    chk("t4_lost_time", lost_cyc - ref_cyc, 100);
    chk("t4_period0",   bus.Period_count, 0);
    chk("t4_high0",     bus.High_count, 0);
    @(negedge Clock);
    n0 = nstb;
    wave(10, 10, 1);
    chk("t4_arm_nostb", nstb, n0);
    chk("t4_arm_lost",  bus.Signal_lost, 1);
    wave(10, 10, 1);
    chk("t4_relock",    nstb, n0 + 1);
    chk("t4_rl_period", last_p, 20);
    chk("t4_rl_lost",   bus.Signal_lost, 0);

    // Period exactly at the timeout is still valid
    wave(50, 50, 2);
    chk("t5_p100",    last_p, 100);
    chk("t5_h100",    last_h, 50);
    chk("t5_l100",    last_l, 50);
    chk("t5_lost100", bus.Signal_lost, 0);
    // One cycle longer times out before the rise
    wave(50, 51, 1);
    n0 = nstb;
    wave(10, 10, 1);
    chk("t5_101_nostb", nstb, n0);
    chk("t5_101_lost",  bus.Signal_lost, 1);
    chk("t5_101_per",   bus.Period_count, 0);

    // Relock, then asynchronous reset in the middle of a high phase
    wave(10, 10, 2);
    chk("t6_locked", bus.Signal_lost, 0);
    chk("t6_per",    bus.Period_count, 20);
    bus.Signal_in = 1'b1;
    repeat (5) @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1 chk_cleared("t6_async");
    bus.Signal_in = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    n0 = nstb;
    wave(10, 10, 1);
    chk("t6_arm_nostb", nstb, n0);
    chk("t6_arm_lost",  bus.Signal_lost, 1);
    wave(10, 10, 1);
    chk("t6_relock",    nstb, n0 + 1);
    chk("t6_rl_high",   last_h, 10);
    chk("t6_rl_lost",   bus.Signal_lost, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
